good_bullet_pool: RTL and testbench

- Player-side projectile engine. It is the opposite direction of the enemy bullet path: it spawns bullets at the player, moves them rightward (+x) and detects collision with the enemy.
- Holds up to N_SLOTS bullets simultaneously and enforces a fire cooldown.
- Sits in GameControl between the player input/state logic and the enemy health/render logic.
- All coordinates are world-space signed values, centre-referenced, using game_pkg constants.

---
 rtl/game_pkg.sv | 21 ++
 rtl/good_bullet_slot.sv | 82 ++++++++
 rtl/good_bullet_pool.sv | 126 ++++++++++++
 tb/tb_good_bullet_pool.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared world-space game constants and the player bullet record
package game_pkg;

    localparam int PLAYER_X       = 16;
    localparam int PLAYER_Y       = 32;
    localparam int SQUAT_PLAYER_Y = 16;
    localparam int BULLET_X       = 4;
    localparam int BULLET_Y       = 2;
    localparam int BULLET_STEP_X  = 8;
    localparam int MAP_X          = 512;

    localparam int GOOD_BULLET_SLOTS    = 4;
    localparam int GOOD_BULLET_COOLDOWN = 12;

    typedef struct packed {
        logic              live;
        logic signed [10:0] x;
        logic signed [9:0]  y;
    } bullet_t;

endpackage

// File: rtl/good_bullet_slot.sv
// rtl/good_bullet_slot.sv - one player bullet: spawn, rightward move, enemy collision, map expiry
module good_bullet_slot
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               spawn,
    input  logic signed [10:0] spawn_x,
    input  logic signed [9:0]  spawn_y,
    input  logic signed [10:0] x_enemy,
    input  logic signed [9:0]  y_enemy,
    input  logic               enemy_squat,
    input  logic               enemy_defend,
    output logic               live,
    output logic signed [10:0] x,
    output logic signed [9:0]  y,
    output logic               hit,
    output logic               block
);

    localparam logic signed [11:0] STEP = 12'(BULLET_STEP_X);
    localparam logic signed [11:0] BX   = 12'(BULLET_X);
    localparam logic signed [11:0] BY   = 12'(BULLET_Y);
    localparam logic signed [11:0] PX   = 12'(PLAYER_X);
    localparam logic signed [11:0] PY   = 12'(PLAYER_Y);
    localparam logic signed [11:0] SY   = 12'(SQUAT_PLAYER_Y);
    localparam logic signed [11:0] MX   = 12'(MAP_X);

    bullet_t bullet_q, bullet_d;

    logic signed [11:0] xw, yw, xe, ye, half, nx;
    logic               collide;

    // 12-bit signed so box edges near the map border never wrap
    always_comb begin
        xw   = {bullet_q.x[10], bullet_q.x};
        yw   = {{2{bullet_q.y[9]}}, bullet_q.y};
        xe   = {x_enemy[10], x_enemy};
        ye   = {{2{y_enemy[9]}}, y_enemy};
        half = enemy_squat ? SY : PY;
        nx   = xw + STEP;
        collide = (nx + BX > xe - PX) && (nx - BX < xe + PX) &&
                  !((yw - BY > ye + half) || (yw + BY < ye - half));
    end

    always_comb begin
        bullet_d = bullet_q;
        hit      = 1'b0;
        block    = 1'b0;
        if (tick) begin
            if (spawn) begin
                bullet_d.live = 1'b1;
                bullet_d.x    = spawn_x;
                bullet_d.y    = spawn_y;
            end else if (bullet_q.live) begin
                if (collide) begin
                    bullet_d.live = 1'b0;
                    hit           = !enemy_defend;
                    block         = enemy_defend;
                end else if (nx > MX - BX) begin
                    bullet_d.live = 1'b0;
                end else begin
                    bullet_d.x = nx[10:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bullet_q <= '0;
        end else begin
            bullet_q <= bullet_d;
        end
    end

    assign live = bullet_q.live;
    assign x    = bullet_q.x;
    assign y    = bullet_q.y;

endmodule

// File: rtl/good_bullet_pool.sv
// rtl/good_bullet_pool.sv - player bullet pool with allocator, fire cooldown and hit popcount
// Optional GOOD_BULLET_EDGE_FIRE_EN: fire on rising edge of attack instead of level.
module good_bullet_pool
    import game_pkg::*;
#(
    parameter int N_SLOTS  = GOOD_BULLET_SLOTS,
    parameter int COOLDOWN = GOOD_BULLET_COOLDOWN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic                           attack,
    input  logic                           defend,
    input  logic signed [10:0]             xPlayer,
    input  logic signed [9:0]              yPlayer,
    input  logic signed [10:0]             xEnemy,
    input  logic signed [9:0]              yEnemy,
    input  logic                           enemySquat,
    input  logic                           enemyDefend,
    output logic signed [11*N_SLOTS-1:0]   x,
    output logic signed [10*N_SLOTS-1:0]   y,
    output logic [N_SLOTS-1:0]             isE,
    output logic                           isHit,
    output logic                           isBlock,
    output logic [$clog2(N_SLOTS+1)-1:0]   dmg
);

    localparam int DW = $clog2(N_SLOTS + 1);
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [CW-1:0]      cd_q, cd_d;
    logic               hit_q, hit_d, blk_q, blk_d;
    logic [DW-1:0]      dmg_q, dmg_d;
    logic [N_SLOTS-1:0] live, slot_hit, slot_blk, spawn;
    logic               fire_req, fire, found;
    logic signed [10:0] spawn_x;

`ifdef GOOD_BULLET_EDGE_FIRE_EN
    logic attack_prev_q, attack_prev_d;

    assign fire_req = attack & ~attack_prev_q;

    always_comb begin
        attack_prev_d = tick ? attack : attack_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            attack_prev_q <= 1'b0;
        end else begin
            attack_prev_q <= attack_prev_d;
        end
    end
`else
    assign fire_req = attack;
`endif

    assign spawn_x = xPlayer + 11'(PLAYER_X + BULLET_X);

    // Occupancy is the registered live vector, so a slot freed this tick waits a tick
    always_comb begin
        spawn = '0;
        found = 1'b0;
        fire  = tick && fire_req && !defend && (cd_q == '0) && !(&live);
        for (int i = 0; i < N_SLOTS; i++) begin
            if (fire && !found && !live[i]) begin
                spawn[i] = 1'b1;
                found    = 1'b1;
            end
        end

        cd_d = cd_q;
        if (fire) begin
            cd_d = CW'(COOLDOWN);
        end else if (tick && (cd_q != '0)) begin
            cd_d = cd_q - 1'b1;
        end

        dmg_d = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            dmg_d = dmg_d + DW'(slot_hit[i]);
        end
        hit_d = |slot_hit;
        blk_d = |slot_blk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cd_q  <= '0;
            hit_q <= 1'b0;
            blk_q <= 1'b0;
            dmg_q <= '0;
        end else begin
            cd_q  <= cd_d;
            hit_q <= hit_d;
            blk_q <= blk_d;
            dmg_q <= dmg_d;
        end
    end

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        good_bullet_slot u_slot (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .spawn        (spawn[i]),
            .spawn_x      (spawn_x),
            .spawn_y      (yPlayer),
            .x_enemy      (xEnemy),
            .y_enemy      (yEnemy),
            .enemy_squat  (enemySquat),
            .enemy_defend (enemyDefend),
            .live         (live[i]),
            .x            (x[11*i +: 11]),
            .y            (y[10*i +: 10]),
            .hit          (slot_hit[i]),
            .block        (slot_blk[i])
        );
    end

    assign isE     = live;
    assign isHit   = hit_q;
    assign isBlock = blk_q;
    assign dmg     = dmg_q;

endmodule

// File: tb/tb_good_bullet_pool.sv
// tb/tb_good_bullet_pool.sv - scoreboard bench for good_bullet_pool (N_SLOTS=4, COOLDOWN=12)
module tb_good_bullet_pool;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, tick = 1'b0, attack = 1'b0, defend = 1'b0;
    logic enemySquat = 1'b0, enemyDefend = 1'b0;
    logic signed [10:0] xPlayer = '0, xEnemy = '0;
    logic signed [9:0]  yPlayer = '0, yEnemy = '0;
    logic signed [43:0] x;
    logic signed [39:0] y;
    logic [3:0] isE;
    logic       isHit, isBlock;
    logic [2:0] dmg;

    good_bullet_pool #(.N_SLOTS(4), .COOLDOWN(12)) dut (
        .clk(clk), .rst(rst), .tick(tick), .attack(attack), .defend(defend),
        .xPlayer(xPlayer), .yPlayer(yPlayer), .xEnemy(xEnemy), .yEnemy(yEnemy),
        .enemySquat(enemySquat), .enemyDefend(enemyDefend),
        .x(x), .y(y), .isE(isE), .isHit(isHit), .isBlock(isBlock), .dmg(dmg)
    );

    typedef struct {
        string      name;
        bit         cs;
        logic [3:0] ise;
        int         slot;
        logic [10:0] ex;
        logic [9:0]  ey;
        bit         h;
        bit         b;
        int         d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;
    logic obs_q = 1'b0;

    always @(posedge clk) obs_q <= tick | rst;

    // Monitor: every tick/reset result pops one expectation; other cycles must be pulse-free
    always @(negedge clk) begin
        exp_t e;
        if (obs_q) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow: result observed with nothing queued");
            end else begin
                e = sb.pop_front();
                if (isHit !== e.h || isBlock !== e.b || dmg !== 3'(e.d)) begin
                    failures++;
                    $display("FAIL %s pulses: got hit=%b block=%b dmg=%0d want hit=%b block=%b dmg=%0d",
                             e.name, isHit, isBlock, dmg, e.h, e.b, e.d);
                end
                if (e.cs) begin
                    checks++;
                    if (isE !== e.ise || x[11*e.slot +: 11] !== e.ex || y[10*e.slot +: 10] !== e.ey) begin
                        failures++;
                        $display("FAIL %s state: got isE=%b x%0d=%0d y%0d=%0d want isE=%b x=%0d y=%0d",
                                 e.name, isE, e.slot, $signed(x[11*e.slot +: 11]), e.slot,
                                 $signed(y[10*e.slot +: 10]), e.ise, $signed(e.ex), $signed(e.ey));
                    end
                end
            end
        end else begin
            checks++;
            if (isHit !== 1'b0 || isBlock !== 1'b0 || dmg !== 3'd0) begin
                failures++;
                $display("FAIL idle_pulse: got hit=%b block=%b dmg=%0d want 0 0 0", isHit, isBlock, dmg);
            end
        end
    end

    task automatic push_tick(input string n, input bit cs, input logic [3:0] ise, input int slot,
                             input int ex, input int ey, input bit h, input bit b, input int d);
        exp_t e;
        e.name = n; e.cs = cs; e.ise = ise; e.slot = slot;
        e.ex = 11'(ex); e.ey = 10'(ey); e.h = h; e.b = b; e.d = d;
        sb.push_back(e);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic skip(input string n);
        push_tick(n, 1'b0, 4'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset(input int slot);
        exp_t e;
        e.name = "reset"; e.cs = 1'b1; e.ise = 4'b0; e.slot = slot;
        e.ex = '0; e.ey = '0; e.h = 1'b0; e.b = 1'b0; e.d = 0;
        rst = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic hit_run(input string n, input bit blk);
        do_reset(0);
        xEnemy = 11'sd50; yEnemy = 10'sd0; enemyDefend = blk;
        attack = 1'b1;
        push_tick({n, "_spawn"}, 1'b1, 4'b0001, 0, 20, int'(yPlayer), 1'b0, 1'b0, 0);
        attack = 1'b0;
        push_tick({n, "_near"}, 1'b1, 4'b0001, 0, 28, int'(yPlayer), 1'b0, 1'b0, 0);
        push_tick({n, "_coll"}, 1'b1, 4'b0000, 1, 0, 0, !blk, blk, blk ? 0 : 1);
        enemyDefend = 1'b0;
    endtask

    initial begin
        // spawn and move, enemy far away
        do_reset(0);
        xEnemy = 11'sd400; yEnemy = 10'sd300; xPlayer = '0; yPlayer = '0;
        attack = 1'b1;
        push_tick("spawn", 1'b1, 4'b0001, 0, 20, 0, 1'b0, 1'b0, 0);
        attack = 1'b0;
        push_tick("move1", 1'b1, 4'b0001, 0, 28, 0, 1'b0, 1'b0, 0);
        push_tick("move2", 1'b1, 4'b0001, 0, 36, 0, 1'b0, 1'b0, 0);
        push_tick("move3", 1'b1, 4'b0001, 1, 0, 0, 1'b0, 1'b0, 0);

        // damaging hit then guarded block
        hit_run("hit", 1'b0);
        hit_run("block", 1'b1);

        // y offset 20: overlaps full-height enemy, clears squatting enemy
        yPlayer = 10'sd20;
        hit_run("tallhit", 1'b0);

        do_reset(0);
        enemySquat = 1'b1; xEnemy = 11'sd50; yEnemy = 10'sd0;
        attack = 1'b1;
        push_tick("squat_spawn", 1'b1, 4'b0001, 0, 20, 20, 1'b0, 1'b0, 0);
        attack = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            if (k == 2)       push_tick("squat_pass", 1'b1, 4'b0001, 0, 36, 20, 1'b0, 1'b0, 0);
            else if (k == 61) push_tick("map_edge", 1'b1, 4'b0001, 0, 508, 20, 1'b0, 1'b0, 0);
            else if (k == 62) push_tick("map_expire", 1'b1, 4'b0000, 1, 0, 0, 1'b0, 1'b0, 0);
            else              skip("squat_fly");
        end
        enemySquat = 1'b0; yPlayer = '0;

        // cooldown and full pool, enemy out of reach
        do_reset(0);
        xEnemy = 11'sd400; yEnemy = 10'sd300;
`ifdef GOOD_BULLET_EDGE_FIRE_EN
        attack = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (t == 0)       push_tick("edge_first", 1'b1, 4'b0001, 0, 20, 0, 1'b0, 1'b0, 0);
            else if (t == 49) push_tick("edge_held", 1'b1, 4'b0001, 0, 412, 0, 1'b0, 1'b0, 0);
            else              skip("edge_hold");
        end
        attack = 1'b0;
        push_tick("edge_release", 1'b1, 4'b0001, 0, 420, 0, 1'b0, 1'b0, 0);
        attack = 1'b1;
        push_tick("edge_refire", 1'b1, 4'b0011, 1, 20, 0, 1'b0, 1'b0, 0);
        attack = 1'b0;
`else
        attack = 1'b1;
        for (int t = 0; t < 64; t++) begin
            case (t)
                0:       push_tick("cd_t0",  1'b1, 4'b0001, 0, 20,  0, 1'b0, 1'b0, 0);
                12:      push_tick("cd_t12", 1'b1, 4'b0001, 0, 116, 0, 1'b0, 1'b0, 0);
                13:      push_tick("cd_t13", 1'b1, 4'b0011, 1, 20,  0, 1'b0, 1'b0, 0);
                26:      push_tick("cd_t26", 1'b1, 4'b0111, 2, 20,  0, 1'b0, 1'b0, 0);
                39:      push_tick("cd_t39", 1'b1, 4'b1111, 3, 20,  0, 1'b0, 1'b0, 0);
                61:      push_tick("full_t61", 1'b1, 4'b1111, 0, 508, 0, 1'b0, 1'b0, 0);
                62:      push_tick("free_t62", 1'b1, 4'b1110, 1, 412, 0, 1'b0, 1'b0, 0);
                63:      push_tick("reuse_t63", 1'b1, 4'b1111, 0, 20, 0, 1'b0, 1'b0, 0);
                default: skip("cd_hold");
            endcase
        end
        attack = 1'b0;
`endif

        // defend inhibits fire
        do_reset(0);
        defend = 1'b1; attack = 1'b1;
        push_tick("defend_inhibit", 1'b1, 4'b0000, 0, 0, 0, 1'b0, 1'b0, 0);
        defend = 1'b0; attack = 1'b0;

        // three bullets in flight, then reset clears them silently
        do_reset(0);
        for (int t = 0; t < 27; t++) begin
            attack = (t == 0 || t == 13 || t == 26);
            if (t == 26) push_tick("three_live", 1'b1, 4'b0111, 2, 20, 0, 1'b0, 1'b0, 0);
            else         skip("three_fly");
        end
        attack = 1'b0;
        do_reset(2);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
